// File: rtl/alu_pkg.sv
// Op codes and flag bit positions shared by alu_seq_core and its bench.
// make_flags() places the four status bits at their named positions.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_ASR  = 4'd8;
  localparam logic [3:0] OP_PASSB = 4'd9;
  localparam logic [3:0] OP_ACC  = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd12;
  localparam logic [3:0] OP_MULH = 4'd13;

  localparam int FLG_Z = 0;
  localparam int FLG_N = 1;
  localparam int FLG_C = 2;
  localparam int FLG_V = 3;

  function automatic logic [3:0] make_flags(input logic v, input logic c,
                                            input logic n, input logic z);
    logic [3:0] f;
    f        = '0;
    f[FLG_V] = v;
    f[FLG_C] = c;
    f[FLG_N] = n;
    f[FLG_Z] = z;
    return f;
  endfunction

endpackage

// File: rtl/alu_mul_shift.sv
// Iterative unsigned shift-add multiplier, one partial product per step (WIDTH steps).
// Only compiled when ALU_MUL_EN is defined; product_next is the value the next step will store.
`ifdef ALU_MUL_EN
module alu_mul_shift #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 step,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product_next
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   sum;

  // lo holds the unconsumed multiplier bits and shifts in product bits from the top
  assign sum          = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
  assign product_next = {sum, lo[WIDTH-1:1]};
  assign done         = (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
    end else if (load) begin
      mcand <= a;
      hi    <= '0;
      lo    <= b;
      cnt   <= CNT_LAST;
    end else if (step) begin
      {hi, lo} <= product_next;
      if (cnt != '0) cnt <= cnt - CW'(1);
    end
  end

endmodule
`endif

// File: rtl/alu_seq_core.sv
// Registered ALU with start/busy/valid handshake, accumulator op and {V,C,N,Z} flags.
// Define ALU_MUL_EN to build the multi-cycle multiplier for MUL/MULH; otherwise they are undefined ops.
//
// state   | meaning
// IDLE    | ready; single-cycle ops complete on their accept edge
// MUL     | multiplier stepping; start ignored; result_valid low
module alu_seq_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam int SHW = $clog2(WIDTH);

  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   add_ext;
  logic [WIDTH:0]   sub_ext;
  logic [WIDTH:0]   acc_ext;
  logic [WIDTH:0]   shl_ext;
  logic [WIDTH:0]   shr_ext;
  logic [WIDTH:0]   asr_ext;
  logic [WIDTH-1:0] res_d;
  logic             c_d;
  logic             v_d;
  logic [3:0]       flg_d;

  logic             accept;
  logic             is_mul_op;
  logic             mul_finish;
  logic [WIDTH-1:0] mul_res;
  logic [3:0]       mul_flg;

  assign accept = ena && start && !busy;
  assign shamt  = b[SHW-1:0];

  // Shifts carry the last bit shifted out in the extra bit; a zero shift leaves it 0
  assign add_ext = {1'b0, a} + {1'b0, b};
  assign sub_ext = {1'b0, a} - {1'b0, b};
  assign acc_ext = {1'b0, result} + {1'b0, a};
  assign shl_ext = {1'b0, a} << shamt;
  assign shr_ext = {a, 1'b0} >> shamt;
  assign asr_ext = $signed({a, 1'b0}) >>> shamt;

  function automatic logic add_ovf(input logic x, input logic y, input logic s);
    return (x == y) && (s != x);
  endfunction

  always_comb begin
    res_d = '0;
    c_d   = 1'b0;
    v_d   = 1'b0;
    case (op)
      OP_ADD: begin
        res_d = add_ext[WIDTH-1:0];
        c_d   = add_ext[WIDTH];
        v_d   = add_ovf(a[WIDTH-1], b[WIDTH-1], add_ext[WIDTH-1]);
      end
      OP_SUB: begin
        res_d = sub_ext[WIDTH-1:0];
        c_d   = !sub_ext[WIDTH];
        v_d   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:   res_d = a & b;
      OP_OR:    res_d = a | b;
      OP_XOR:   res_d = a ^ b;
      OP_NOT:   res_d = ~a;
      OP_SHL: begin
        res_d = shl_ext[WIDTH-1:0];
        c_d   = shl_ext[WIDTH];
      end
      OP_SHR: begin
        res_d = shr_ext[WIDTH:1];
        c_d   = shr_ext[0];
      end
      OP_ASR: begin
        res_d = asr_ext[WIDTH:1];
        c_d   = asr_ext[0];
      end
      OP_PASSB: res_d = b;
      OP_ACC: begin
        res_d = acc_ext[WIDTH-1:0];
        c_d   = acc_ext[WIDTH];
        v_d   = add_ovf(result[WIDTH-1], a[WIDTH-1], acc_ext[WIDTH-1]);
      end
      default: res_d = '0;
    endcase
    flg_d = make_flags(v_d, c_d, res_d[WIDTH-1], res_d == '0);
  end

`ifdef ALU_MUL_EN
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

  logic [0:0]         state;
  logic               mul_hi;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  assign is_mul_op  = (op == OP_MUL) || (op == OP_MULH);
  assign busy       = (state == ST_MUL);
  assign mul_finish = ena && busy && mul_done;

  alu_mul_shift #(.WIDTH(WIDTH)) u_mul (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (accept && is_mul_op),
    .step         (ena && busy),
    .a            (a),
    .b            (b),
    .done         (mul_done),
    .product_next (mul_prod)
  );

  assign mul_res = mul_hi ? mul_prod[2*WIDTH-1:WIDTH] : mul_prod[WIDTH-1:0];
  assign mul_flg = make_flags(1'b0, !mul_hi && (mul_prod[2*WIDTH-1:WIDTH] != '0),
                              mul_res[WIDTH-1], mul_res == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      mul_hi <= 1'b0;
    end else if (accept && is_mul_op) begin
      state  <= ST_MUL;
      mul_hi <= (op == OP_MULH);
    end else if (mul_finish) begin
      state  <= ST_IDLE;
    end
  end
`else
  assign is_mul_op  = 1'b0;
  assign busy       = 1'b0;
  assign mul_finish = 1'b0;
  assign mul_res    = '0;
  assign mul_flg    = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result       <= '0;
      flags        <= '0;
      result_valid <= 1'b0;
    end else if (accept) begin
      if (is_mul_op) begin
        result_valid <= 1'b0;
      end else begin
        result       <= res_d;
        flags        <= flg_d;
        result_valid <= 1'b1;
      end
    end else if (mul_finish) begin
      result       <= mul_res;
      flags        <= mul_flg;
      result_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_seq_core.sv
// Scoreboard bench for alu_seq_core (WIDTH=8): directed vectors plus random ops against an arithmetic model.
module tb_alu_seq_core;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       start = 1'b0;
  logic [3:0] op = '0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       busy;
  logic       result_valid;
  logic [7:0] result;
  logic [3:0] flags;

  alu_seq_core #(.WIDTH(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .start        (start),
    .op           (op),
    .a            (a),
    .b            (b),
    .busy         (busy),
    .result_valid (result_valid),
    .result       (result),
    .flags        (flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    int         issue;
    bit         is_mul;
    logic [7:0] res;
    logic [3:0] flg;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         mul_free_edge = 0;
  logic [7:0] model_acc = '0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on the op definitions
  function automatic void model(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                                input logic [7:0] acc, output logic [7:0] r, output logic [3:0] f);
    int ux, uy, sx, sy, sacc, t, sh;
    bit c, v;
    ux = x; uy = y; sx = $signed(x); sy = $signed(y); sacc = $signed(acc);
    sh = uy % 8; t = 0; c = 0; v = 0;
    case (o)
      OP_ADD: begin t = ux + uy; c = (t > 255); v = (sx + sy > 127) || (sx + sy < -128); end
      OP_SUB: begin t = ux - uy; c = (ux >= uy); v = (sx - sy > 127) || (sx - sy < -128); end
      OP_AND: t = ux & uy;
      OP_OR:  t = ux | uy;
      OP_XOR: t = ux ^ uy;
      OP_NOT: t = ~ux;
      OP_SHL: begin t = ux << sh; c = (sh != 0) && (((ux >> (8 - sh)) & 1) == 1); end
      OP_SHR: begin t = ux >> sh; c = (sh != 0) && (((ux >> (sh - 1)) & 1) == 1); end
      OP_ASR: begin t = sx >>> sh; c = (sh != 0) && (((ux >> (sh - 1)) & 1) == 1); end
      OP_PASSB: t = uy;
      OP_ACC: begin
        t = int'(acc) + ux; c = (t > 255); v = (sacc + sx > 127) || (sacc + sx < -128);
      end
`ifdef ALU_MUL_EN
      OP_MUL:  begin t = ux * uy; c = (t > 255); end
      OP_MULH: t = (ux * uy) / 256;
`endif
      default: t = 0;
    endcase
    r = t[7:0];
    f = {v, c, r[7], (r == 8'h00)};
  endfunction

  // An ena=0 edge while a multiply is in flight pushes its completion out by one
  task automatic freeze(input int e);
    if (e < mul_free_edge) begin
      mul_free_edge++;
      foreach (q[i]) if (q[i].is_mul && q[i].due >= e) q[i].due++;
    end
  endtask

  task automatic issue(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y, input bit en);
    int   e;
    exp_t it;
    @(negedge clk);
    start = 1'b1; ena = en; op = o; a = x; b = y;
    e = cyc + 1;
    if (!en) begin
      freeze(e);
    end else if (e >= mul_free_edge) begin
      model(o, x, y, model_acc, it.res, it.flg);
      model_acc = it.res;
      it.issue  = e;
      it.due    = e;
      it.is_mul = 1'b0;
`ifdef ALU_MUL_EN
      if (o == OP_MUL || o == OP_MULH) begin
        it.is_mul     = 1'b1;
        it.due        = e + 8;
        mul_free_edge = e + 9;
      end
`endif
      q.push_back(it);
    end
  endtask

  task automatic idle(input int n, input bit en);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0; ena = en;
      if (!en) freeze(cyc + 1);
    end
  endtask

  task automatic model_reset();
    q.delete();
    model_acc     = '0;
    mul_free_edge = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; ena = 1'b1;
    model_reset();
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", flags, 0);
    rst_n = 1'b1;
  endtask

  // Monitor: compares whatever the DUT presents against the queue head
  always @(negedge clk) begin
    if (rst_n && q.size() > 0) begin
      if (q[0].is_mul && cyc >= q[0].issue && cyc < q[0].due) begin
        chk("mul_busy", busy, 1);
        chk("mul_valid_low", result_valid, 0);
      end
      if (q[0].due == cyc) begin
        chk("valid", result_valid, 1);
        chk("result", result, q[0].res);
        chk("flags", flags, q[0].flg);
        void'(q.pop_front());
      end else if (q[0].due < cyc) begin
        checks++; errors++;
        $display("FAIL missed_result: due cycle %0d, now %0d", q[0].due, cyc);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    int guard;
    do_reset();

    issue(OP_ADD, 8'hF0, 8'h20, 1);
    issue(OP_SUB, 8'h80, 8'h01, 1);
    issue(OP_SUB, 8'h05, 8'h05, 1);
    issue(OP_SHL, 8'h81, 8'h01, 1);
    issue(OP_ASR, 8'h80, 8'h03, 1);
    issue(OP_SHR, 8'h81, 8'h00, 1);
    issue(OP_ADD, 8'h05, 8'h03, 1);
    issue(OP_ACC, 8'h02, 8'h00, 1);
    idle(2, 1);

    do_reset();
    issue(OP_ACC, 8'h02, 8'h00, 1);
    idle(2, 1);

    issue(OP_MUL, 8'h0D, 8'h0B, 1);
    issue(OP_ADD, 8'h11, 8'h22, 1);
    idle(8, 1);
    issue(OP_MULH, 8'hFF, 8'hFF, 1);
    idle(9, 1);

    issue(OP_MUL, 8'h37, 8'h5A, 1);
    idle(2, 1);
    idle(3, 0);
    idle(8, 1);
    issue(OP_ADD, 8'h01, 8'h01, 0);
    issue(OP_PASSB, 8'h00, 8'hA5, 1);

    issue(4'd15, 8'h12, 8'h34, 1);
    issue(4'd11, 8'hFF, 8'hFF, 1);
    issue(4'd14, 8'h01, 8'h02, 1);
    idle(2, 1);

    // Async reset during the fourth multiply cycle
    issue(OP_ADD, 8'h05, 8'h03, 1);
    issue(OP_MUL, 8'h0D, 8'h0B, 1);
    idle(3, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", result_valid, 0);
    chk("midrst_result", result, 0);
    chk("midrst_flags", flags, 0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(OP_ACC, 8'h02, 8'h00, 1);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) < 8)
        issue(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), $urandom_range(0, 9) != 0);
      else
        idle(1, $urandom_range(0, 9) != 0);
    end

    guard = 0;
    while (q.size() > 0 && guard < 100) begin
      idle(1, 1);
      guard++;
    end
    if (q.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d results still pending", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
